// File: rtl/gpio_walk_checker.sv
// gpio_walk_checker
//   Loopback checker for a walking-one GPIO pattern. The bus is synchronised,
//   debounced, and then tracked as a rotate-left sequence. Once the checker is
//   locked, every break in the sequence is flagged and counted.
//
//   state  | meaning
//   -------+-------------------------------------------------------------
//   HUNT   | waiting for a one-hot word to start tracking
//   TRACK  | following the sequence; good = consecutive correct words
//   LOCKED | sequence confirmed; mismatches are counted as errors
//
//   Ports
//     osc         system clock, rising edge
//     perstn      asynchronous active-low reset
//     gpio_in     bus under test, asynchronous to osc
//     clear       synchronous pulse: zero err_count, return to HUNT
//     word_valid  one-cycle strobe when a new word is accepted
//     last_word   most recently accepted word
//     locked      high in LOCKED
//     err_pulse   one-cycle strobe per detected error
//     err_count   saturating error count
//
//   Optional macro GPIO_CHK_TIMEOUT_EN adds a watchdog. In LOCKED, if TIMEOUT
//   osc cycles pass without a new word, an error is raised and the FSM
//   returns to HUNT.
module gpio_walk_checker #(
    parameter int WIDTH         = 32,
    parameter int STABLE_CYCLES = 4,
    parameter int LOCK_COUNT    = 8,
    parameter int ERR_W         = 16,
    parameter int TIMEOUT       = 1000000
) (
    input  logic             osc,
    input  logic             perstn,
    input  logic [WIDTH-1:0] gpio_in,
    input  logic             clear,
    output logic             word_valid,
    output logic [WIDTH-1:0] last_word,
    output logic             locked,
    output logic             err_pulse,
    output logic [ERR_W-1:0] err_count
);

    localparam int STAB_W = $clog2(STABLE_CYCLES + 1);
    localparam int GOOD_W = $clog2(LOCK_COUNT + 1);

    typedef enum logic [1:0] {HUNT, TRACK, LOCKED} state_t;

    state_t             state;
    logic [GOOD_W-1:0]  good;
    logic [WIDTH-1:0]   sync_1;
    logic [WIDTH-1:0]   sync_q;
    logic [STAB_W-1:0]  stab_cnt;
    logic               accept;
    logic               w_onehot;
    logic               w_match;
    logic [WIDTH-1:0]   exp_word;
    logic               tmo_fire;

    always_ff @(posedge osc or negedge perstn) begin
        if (!perstn) begin
            sync_1 <= '0;
            sync_q <= '0;
        end else begin
            sync_1 <= gpio_in;
            sync_q <= sync_1;
        end
    end

    // sync_1 != sync_q means sync_q takes a new value on this edge.
    always_ff @(posedge osc or negedge perstn) begin
        if (!perstn) begin
            stab_cnt <= '0;
        end else if (sync_1 != sync_q) begin
            stab_cnt <= '0;
        end else if (stab_cnt != STAB_W'(STABLE_CYCLES)) begin
            stab_cnt <= stab_cnt + 1'b1;
        end
    end

    // Accept on the edge where the counter would reach STABLE_CYCLES, so a
    // held word is taken STABLE_CYCLES+1 edges after it enters sync_1.
    assign accept   = (sync_1 == sync_q)
                   && (stab_cnt >= STAB_W'(STABLE_CYCLES - 1))
                   && (sync_q != last_word);
    assign exp_word = {last_word[WIDTH-2:0], last_word[WIDTH-1]};
    assign w_match  = (sync_q == exp_word);
    assign w_onehot = (sync_q != '0) && ((sync_q & (sync_q - 1'b1)) == '0);

`ifdef GPIO_CHK_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT + 1);
    logic [TMO_W-1:0] tmo_cnt;

    always_ff @(posedge osc or negedge perstn) begin
        if (!perstn) begin
            tmo_cnt <= '0;
        end else if (accept || state != LOCKED) begin
            tmo_cnt <= '0;
        end else if (tmo_cnt != TMO_W'(TIMEOUT - 1)) begin
            tmo_cnt <= tmo_cnt + 1'b1;
        end
    end

    assign tmo_fire = (state == LOCKED) && !accept
                   && (tmo_cnt == TMO_W'(TIMEOUT - 1));
`else
    assign tmo_fire = 1'b0;
`endif

    always_ff @(posedge osc or negedge perstn) begin
        if (!perstn) begin
            state      <= HUNT;
            good       <= '0;
            word_valid <= 1'b0;
            last_word  <= '0;
            locked     <= 1'b0;
            err_pulse  <= 1'b0;
            err_count  <= '0;
        end else begin
            word_valid <= accept;
            err_pulse  <= 1'b0;
            if (accept) begin
                last_word <= sync_q;
            end

            if (clear) begin
                state     <= HUNT;
                good      <= '0;
                locked    <= 1'b0;
                err_count <= '0;
            end else if (accept) begin
                case (state)
                    HUNT: begin
                        if (w_onehot) begin
                            state <= TRACK;
                            good  <= GOOD_W'(1);
                        end
                    end
                    TRACK: begin
                        if (w_match) begin
                            good <= good + 1'b1;
                            if (good == GOOD_W'(LOCK_COUNT - 1)) begin
                                state  <= LOCKED;
                                locked <= 1'b1;
                            end
                        end else if (w_onehot) begin
                            good <= GOOD_W'(1);
                        end else begin
                            state <= HUNT;
                            good  <= '0;
                        end
                    end
                    LOCKED: begin
                        if (!w_match) begin
                            err_pulse <= 1'b1;
                            locked    <= 1'b0;
                            if (err_count != {ERR_W{1'b1}}) begin
                                err_count <= err_count + 1'b1;
                            end
                            if (w_onehot) begin
                                state <= TRACK;
                                good  <= GOOD_W'(1);
                            end else begin
                                state <= HUNT;
                                good  <= '0;
                            end
                        end
                    end
                    default: begin
                        state <= HUNT;
                        good  <= '0;
                    end
                endcase
            end else if (tmo_fire) begin
                err_pulse <= 1'b1;
                locked    <= 1'b0;
                state     <= HUNT;
                good      <= '0;
                if (err_count != {ERR_W{1'b1}}) begin
                    err_count <= err_count + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_gpio_walk_checker.sv
module tb_gpio_walk_checker;

    logic        osc;
    logic        perstn;
    logic [31:0] gpio_in;
    logic        clear;
    logic        word_valid;
    logic [31:0] last_word;
    logic        locked;
    logic        err_pulse;
    logic [15:0] err_count;

    int n_pass  = 0;
    int n_total = 0;

    gpio_walk_checker dut (
        .osc        (osc),
        .perstn     (perstn),
        .gpio_in    (gpio_in),
        .clear      (clear),
        .word_valid (word_valid),
        .last_word  (last_word),
        .locked     (locked),
        .err_pulse  (err_pulse),
        .err_count  (err_count)
    );

    initial osc = 1'b0;
    always #5 osc = ~osc;

    typedef struct {
        logic [31:0] word;
        logic        exp_locked;
        logic        exp_pulse;
        logic [15:0] exp_cnt;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // Drive a word at a falling edge and wait for word_valid. Latency is the
    // number of rising edges from the first one that sees the word up to and
    // including the accepting edge; expected STABLE_CYCLES+2 = 6.
    task automatic apply(input logic [31:0] word, output int lat);
        gpio_in = word;
        lat = 0;
        for (int n = 1; n <= 20; n++) begin
            @(negedge osc);
            if (word_valid) begin
                lat = n;
                break;
            end
        end
    endtask

    task automatic step(input vec_t v, input string tag);
        int lat;
        apply(v.word, lat);
        chk({tag, " latency"}, lat, 6);
        chk({tag, " last_word"}, last_word, v.word);
        chk({tag, " locked"}, {31'b0, locked}, {31'b0, v.exp_locked});
        chk({tag, " err_pulse"}, {31'b0, err_pulse}, {31'b0, v.exp_pulse});
        chk({tag, " err_count"}, {16'b0, err_count}, {16'b0, v.exp_cnt});
        @(negedge osc);
        chk({tag, " strobe width"}, {31'b0, word_valid}, 32'd0);
        repeat (3) @(negedge osc);
    endtask

    initial begin
        int lat;
        int cnt;
        vec_t v;

        // Walk from reset word 1 up to bit 31 (lock at 0x80), wrap, then a
        // break at 0x10 -> 0x40 and a relock on the 7th following step.
        for (int i = 1; i < 32; i++) begin
            v.word = 32'd1 << i; v.exp_locked = (i >= 7); v.exp_pulse = 0; v.exp_cnt = 0;
            vecs.push_back(v);
        end
        for (int i = 0; i < 5; i++) begin
            v.word = 32'd1 << i; v.exp_locked = 1; v.exp_pulse = 0; v.exp_cnt = 0;
            vecs.push_back(v);
        end
        v.word = 32'h40; v.exp_locked = 0; v.exp_pulse = 1; v.exp_cnt = 1;
        vecs.push_back(v);
        for (int j = 7; j <= 14; j++) begin
            v.word = 32'd1 << j; v.exp_locked = (j >= 13); v.exp_pulse = 0; v.exp_cnt = 1;
            vecs.push_back(v);
        end

        // Reset while the bus already shows 1.
        perstn  = 1'b0;
        clear   = 1'b0;
        gpio_in = 32'h1;
        #100;
        chk("rst word_valid", {31'b0, word_valid}, 32'd0);
        chk("rst last_word", last_word, 32'd0);
        chk("rst locked", {31'b0, locked}, 32'd0);
        chk("rst err_pulse", {31'b0, err_pulse}, 32'd0);
        chk("rst err_count", {16'b0, err_count}, 32'd0);
        @(negedge osc);
        perstn = 1'b1;
        apply(32'h1, lat);
        chk("first latency", lat, 6);
        chk("first last_word", last_word, 32'h1);
        @(negedge osc);
        chk("first strobe width", {31'b0, word_valid}, 32'd0);
        repeat (3) @(negedge osc);

        foreach (vecs[i]) step(vecs[i], $sformatf("vec%0d", i));

        // Three-cycle glitch on bit 0 while locked at 0x4000: never accepted.
        cnt = 0;
        gpio_in = 32'h4001;
        repeat (3) @(negedge osc) if (word_valid) cnt++;
        gpio_in = 32'h4000;
        repeat (15) @(negedge osc) if (word_valid) cnt++;
        chk("glitch word_valid count", cnt, 0);
        chk("glitch locked", {31'b0, locked}, 32'd1);

        // Non-one-hot word while locked: error, back to HUNT.
        v.word = 32'h3; v.exp_locked = 0; v.exp_pulse = 1; v.exp_cnt = 2;
        step(v, "nonhot");

        // Relock from HUNT.
        for (int i = 0; i < 8; i++) begin
            v.word = 32'd1 << i; v.exp_locked = (i == 7); v.exp_pulse = 0; v.exp_cnt = 2;
            step(v, $sformatf("relock%0d", i));
        end

        // clear on the same edge as a mismatching word.
        gpio_in = 32'h5;
        repeat (5) @(negedge osc);
        clear = 1'b1;
        @(negedge osc);
        clear = 1'b0;
        chk("clear word_valid", {31'b0, word_valid}, 32'd1);
        chk("clear last_word", last_word, 32'h5);
        chk("clear err_pulse", {31'b0, err_pulse}, 32'd0);
        chk("clear err_count", {16'b0, err_count}, 32'd0);
        chk("clear locked", {31'b0, locked}, 32'd0);
        repeat (4) @(negedge osc);

        // Lock again, then hold the bus static: without the watchdog, locked stays.
        for (int i = 0; i < 8; i++) begin
            v.word = 32'd1 << i; v.exp_locked = (i == 7); v.exp_pulse = 0; v.exp_cnt = 0;
            step(v, $sformatf("lock3_%0d", i));
        end
        cnt = 0;
        repeat (200) @(negedge osc) if (err_pulse || word_valid) cnt++;
        chk("static strobes", cnt, 0);
        chk("static locked", {31'b0, locked}, 32'd1);
        chk("static err_count", {16'b0, err_count}, 32'd0);

        // Asynchronous reset mid-operation.
        #2 perstn = 1'b0;
        #1;
        chk("async rst locked", {31'b0, locked}, 32'd0);
        chk("async rst last_word", last_word, 32'd0);
        perstn = 1'b1;

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
